// File: rtl/cdi_nvram_pkg.sv
// Shared definitions for the NVRAM/timekeeper slave: clock register offsets,
// the BCD time record and the month-length helper.
package cdi_nvram_pkg;

    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_SEC   = 3'd1;
    localparam logic [2:0] REG_MIN   = 3'd2;
    localparam logic [2:0] REG_HOUR  = 3'd3;
    localparam logic [2:0] REG_DAY   = 3'd4;
    localparam logic [2:0] REG_DATE  = 3'd5;
    localparam logic [2:0] REG_MONTH = 3'd6;
    localparam logic [2:0] REG_YEAR  = 3'd7;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic [7:0] day;
        logic [7:0] date;
        logic [7:0] month;
        logic [7:0] year;
    } rtc_time_t;

    localparam rtc_time_t RTC_RESET = '{ctrl: 8'h00, sec: 8'h00, min: 8'h00, hour: 8'h00,
                                        day: 8'h01, date: 8'h01, month: 8'h01, year: 8'h00};

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;

    // Last valid BCD date of the month; year 00 counts as a leap year.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
        int yr;
        yr = 10 * int'(year[7:4]) + int'(year[3:0]);
        case (month)
            8'h02:                      return ((yr % 4) == 0) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/m48t08_rtc_core.sv
// M48T08-style clock: prescaler, BCD calendar chain, W/R/ST control and read snapshot.
// Registers are addressed by a 3-bit offset from 0x1FF8.
module m48t08_rtc_core
    import cdi_nvram_pkg::*;
#(
    parameter int CLK_HZ = 30_000_000
) (
    input  logic       clk30,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_offset,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_offset,
    output logic [7:0] rd_byte
);

    localparam int PW = $clog2(CLK_HZ + 1);

    logic [PW-1:0] presc;
    rtc_time_t     live, snap, nxt, src;
    logic          w_mode, halt, tick;
    logic [8:0]    st_sec, st_min, st_hour, st_date, st_month, st_year;
    logic [2:0]    day_next;

    // Returns {wrapped, next}. Values at or past the limit wrap, so corrupt
    // digits count up in binary until they meet the compare instead of sticking.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] max_v,
                                            input logic [7:0] min_v);
        if (v >= max_v)          return {1'b1, min_v};
        else if (v[3:0] == 4'h9) return {1'b0, v + 8'h07};
        else                     return {1'b0, v + 8'h01};
    endfunction

    assign w_mode = live.ctrl[7];
    assign halt   = live.sec[7] | w_mode;
    assign tick   = !halt && (presc == PW'(CLK_HZ - 1));

    always_comb begin
        st_sec   = bcd_step({1'b0, live.sec[6:0]}, 8'h59, 8'h00);
        st_min   = bcd_step({1'b0, live.min[6:0]}, 8'h59, 8'h00);
        st_hour  = bcd_step({2'b00, live.hour[5:0]}, 8'h23, 8'h00);
        st_date  = bcd_step({2'b00, live.date[5:0]}, days_in_month(live.month, live.year), 8'h01);
        st_month = bcd_step({3'b000, live.month[4:0]}, 8'h12, 8'h01);
        st_year  = bcd_step(live.year, 8'h99, 8'h00);
        day_next = (live.day[2:0] >= 3'd7 || live.day[2:0] == 3'd0) ? 3'd1 : live.day[2:0] + 3'd1;
        nxt      = live;
        if (tick) begin
            nxt.sec = {live.sec[7], 7'h00} | (st_sec[7:0] & 8'h7F);
            if (st_sec[8]) begin
                nxt.min = st_min[7:0] & 8'h7F;
                if (st_min[8]) begin
                    nxt.hour = st_hour[7:0] & 8'h3F;
                    if (st_hour[8]) begin
                        nxt.day  = {1'b0, live.day[6], 3'b000, day_next};
                        nxt.date = st_date[7:0] & 8'h3F;
                        if (st_date[8]) begin
                            nxt.month = st_month[7:0] & 8'h1F;
                            if (st_month[8]) nxt.year = st_year[7:0];
                        end
                    end
                end
            end
        end
        // A bus write lands after the tick; ST and CTRL are writable even while counting.
        if (wr_en) begin
            case (wr_offset)
                REG_CTRL:  nxt.ctrl = wr_data;
                REG_SEC:   nxt.sec  = w_mode ? wr_data : {wr_data[7], nxt.sec[6:0]};
                REG_MIN:   if (w_mode) nxt.min   = wr_data & 8'h7F;
                REG_HOUR:  if (w_mode) nxt.hour  = wr_data & 8'h3F;
                REG_DAY:   if (w_mode) nxt.day   = wr_data & 8'h47;
                REG_DATE:  if (w_mode) nxt.date  = wr_data & 8'h3F;
                REG_MONTH: if (w_mode) nxt.month = wr_data & 8'h1F;
                default:   if (w_mode) nxt.year  = wr_data;
            endcase
        end
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            presc <= '0;
            live  <= RTC_RESET;
        end else begin
            presc <= (halt || tick) ? '0 : presc + PW'(1);
            live  <= nxt;
        end
    end

    // Snapshot taken on the R 0->1 write, from the pre-edge counters.
    always_ff @(posedge clk30) begin
        if (wr_en && wr_offset == REG_CTRL && wr_data[6] && !live.ctrl[6]) snap <= live;
    end

    always_comb begin
        src = live.ctrl[6] ? snap : live;
        case (rd_offset)
            REG_CTRL:  rd_byte = live.ctrl;
            REG_SEC:   rd_byte = src.sec;
            REG_MIN:   rd_byte = src.min;
            REG_HOUR:  rd_byte = src.hour;
            REG_DAY:   rd_byte = src.day;
            REG_DATE:  rd_byte = src.date;
            REG_MONTH: rd_byte = src.month;
            default:   rd_byte = src.year;
        endcase
    end

endmodule

// File: rtl/m48t08_timekeeper.sv
// 8 KiB NVRAM slave with M48T08 clock registers at 0x1FF8-0x1FFF (upper byte lane).
// Define TIMEKEEPER_RTC_EN to build the clock; otherwise the top 8 bytes are plain RAM.
module m48t08_timekeeper
    import cdi_nvram_pkg::*;
#(
    parameter int CLK_HZ = 30_000_000
) (
    input  logic        clk30,
    input  logic        reset,
    input  logic        cs,
    input  logic [12:0] addr,
    input  logic [15:0] din,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    output logic [15:0] dout,
    output logic        bus_ack
);

    bus_state_t state, state_nxt;
    logic [7:0] mem [8192];
    logic       wr_fire, rd_launch;
    logic [7:0] rd_byte;
    logic       unused_lanes;

    assign unused_lanes = ^{lds, din[7:0]};
    assign wr_fire      = cs && write_strobe && uds;

`ifdef TIMEKEEPER_RTC_EN
    logic       rtc_hit;
    logic [7:0] rtc_byte;

    assign rtc_hit = &addr[12:3];

    m48t08_rtc_core #(.CLK_HZ(CLK_HZ)) u_rtc (
        .clk30     (clk30),
        .reset     (reset),
        .wr_en     (wr_fire && rtc_hit),
        .wr_offset (addr[2:0]),
        .wr_data   (din[15:8]),
        .rd_offset (addr[2:0]),
        .rd_byte   (rtc_byte)
    );

    assign rd_byte = rtc_hit ? rtc_byte : mem[addr];
`else
    localparam int unused_clk_hz = CLK_HZ;
    assign rd_byte = mem[addr];
`endif

    always_ff @(posedge clk30) begin
        if (wr_fire) mem[addr] <= din[15:8];
    end

    // Writes ack combinationally; reads take one cycle and never re-launch from ACK.
    always_comb begin
        state_nxt = state;
        rd_launch = 1'b0;
        bus_ack   = cs && write_strobe;
        case (state)
            BUS_IDLE: begin
                if (cs && !write_strobe) begin
                    rd_launch = 1'b1;
                    state_nxt = BUS_ACK;
                end
            end
            default: begin
                bus_ack   = 1'b1;
                state_nxt = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            state <= BUS_IDLE;
            dout  <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (rd_launch) dout <= {rd_byte, rd_byte};
        end
    end

endmodule

// File: tb/tb_m48t08_timekeeper.sv
// Bench for m48t08_timekeeper: vector table for RAM access, random RAM and clock
// traffic against a decimal calendar model, plus hand-written clock/bus corner cases.
module tb_m48t08_timekeeper;

    logic        clk30 = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic [12:0] addr = '0;
    logic [15:0] din = '0;
    logic        uds = 1'b0;
    logic        lds = 1'b0;
    logic        write_strobe = 1'b0;
    logic [15:0] dout;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;

    localparam logic [12:0] A_CTRL  = 13'h1FF8;
    localparam logic [12:0] A_SEC   = 13'h1FF9;
    localparam logic [12:0] A_MIN   = 13'h1FFA;
    localparam logic [12:0] A_HOUR  = 13'h1FFB;
    localparam logic [12:0] A_DAY   = 13'h1FFC;
    localparam logic [12:0] A_DATE  = 13'h1FFD;
    localparam logic [12:0] A_MONTH = 13'h1FFE;
    localparam logic [12:0] A_YEAR  = 13'h1FFF;

    m48t08_timekeeper #(.CLK_HZ(4)) dut (
        .clk30        (clk30),
        .reset        (reset),
        .cs           (cs),
        .addr         (addr),
        .din          (din),
        .uds          (uds),
        .lds          (lds),
        .write_strobe (write_strobe),
        .dout         (dout),
        .bus_ack      (bus_ack)
    );

    always #5 clk30 = ~clk30;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [7:0] d, input logic u, input logic l);
        cs = 1'b1; write_strobe = 1'b1; addr = a; din = {d, ~d}; uds = u; lds = l;
        #1;
        check("write_ack", bus_ack, 1'b1);
        @(posedge clk30); #1;
        cs = 1'b0; write_strobe = 1'b0; uds = 1'b0; lds = 1'b0;
    endtask

    task automatic read_check(input logic [12:0] a, input logic [7:0] exp, input string name);
        cs = 1'b1; write_strobe = 1'b0; addr = a; uds = 1'b1; lds = 1'b1;
        @(posedge clk30); #1;
        check({name, "_ack"}, bus_ack, 1'b1);
        check(name, dout, {exp, exp});
        cs = 1'b0; uds = 1'b0; lds = 1'b0;
        @(posedge clk30); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [12:0] a;
        logic [7:0]  d;
        logic        u;
        logic        l;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [10];

    logic [7:0] ref_mem [int];
    int         ref_addrs [$];

`ifdef TIMEKEEPER_RTC_EN
    int m_sec, m_min, m_hour, m_day, m_date, m_month, m_year;

    function automatic int month_len(input int mo, input int yr);
        if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_tick();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0; m_min++;
            if (m_min == 60) begin
                m_min = 0; m_hour++;
                if (m_hour == 24) begin
                    m_hour = 0;
                    m_day  = m_day % 7 + 1;
                    m_date++;
                    if (m_date > month_len(m_month, m_year)) begin
                        m_date = 1; m_month++;
                        if (m_month == 13) begin
                            m_month = 1;
                            m_year  = (m_year + 1) % 100;
                        end
                    end
                end
            end
        end
    endtask

    // Leaves the clock running (W=0) with the prescaler just cleared.
    task automatic set_time(input int h, input int mi, input int s, input int dy,
                            input int dt, input int mo, input int yr);
        bus_write(A_CTRL, 8'h80, 1'b1, 1'b0);
        bus_write(A_SEC, to_bcd(s), 1'b1, 1'b0);
        bus_write(A_MIN, to_bcd(mi), 1'b1, 1'b0);
        bus_write(A_HOUR, to_bcd(h), 1'b1, 1'b0);
        bus_write(A_DAY, to_bcd(dy), 1'b1, 1'b0);
        bus_write(A_DATE, to_bcd(dt), 1'b1, 1'b0);
        bus_write(A_MONTH, to_bcd(mo), 1'b1, 1'b0);
        bus_write(A_YEAR, to_bcd(yr), 1'b1, 1'b0);
        bus_write(A_CTRL, 8'h00, 1'b1, 1'b0);
    endtask

    // Let exactly n seconds elapse, then freeze the counters with W=1.
    task automatic run_and_freeze(input int n);
        repeat (4 * n) begin @(posedge clk30); #1; end
        bus_write(A_CTRL, 8'h80, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        vecs[0] = '{1'b1, 13'h1000, 8'hA5, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 13'h1000, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{1'b1, 13'h1000, 8'h3C, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 13'h1000, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[4] = '{1'b1, 13'h0000, 8'h01, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 13'h0FFF, 8'h7E, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 8'h01};
        vecs[7] = '{1'b0, 13'h0FFF, 8'h00, 1'b0, 1'b0, 8'h7E};
        vecs[8] = '{1'b1, 13'h1FF7, 8'hC3, 1'b1, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 13'h1FF7, 8'h00, 1'b0, 1'b0, 8'hC3};

        repeat (3) @(posedge clk30);
        #1;
        check("rst_ack", bus_ack, 1'b0);
        check("rst_dout", dout, 16'h0000);
        reset = 1'b0;
        @(posedge clk30); #1;
        check("idle_ack", bus_ack, 1'b0);

`ifdef TIMEKEEPER_RTC_EN
        read_check(A_CTRL, 8'h00, "rst_ctrl");
        read_check(A_DAY, 8'h01, "rst_day");
        read_check(A_DATE, 8'h01, "rst_date");
        read_check(A_MONTH, 8'h01, "rst_month");
        read_check(A_YEAR, 8'h00, "rst_year");
`endif

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d, vecs[i].u, vecs[i].l);
            else            read_check(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            int          a;
            logic [7:0]  d;
            logic        u;
            if (ref_addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
`ifdef TIMEKEEPER_RTC_EN
                a = ($urandom_range(0, 1) == 0) ? $urandom_range(16'h0100, 16'h010F) : $urandom_range(0, 16'h1FF7);
`else
                a = ($urandom_range(0, 1) == 0) ? $urandom_range(16'h1FF0, 16'h1FFF) : $urandom_range(0, 16'h1FFF);
`endif
                d = 8'($urandom);
                u = ($urandom_range(0, 3) != 0);
                bus_write(13'(a), d, u, ~u);
                if (u) begin
                    if (!ref_mem.exists(a)) ref_addrs.push_back(a);
                    ref_mem[a] = d;
                end
            end else begin
                a = ref_addrs[$urandom_range(0, ref_addrs.size() - 1)];
                read_check(13'(a), ref_mem[a], $sformatf("rnd_ram_%0h", a));
            end
        end

`ifdef TIMEKEEPER_RTC_EN
        // Full calendar rollover on one tick
        set_time(23, 59, 59, 7, 31, 12, 99);
        run_and_freeze(1);
        read_check(A_SEC, 8'h00, "roll_sec");
        read_check(A_MIN, 8'h00, "roll_min");
        read_check(A_HOUR, 8'h00, "roll_hour");
        read_check(A_DAY, 8'h01, "roll_day");
        read_check(A_DATE, 8'h01, "roll_date");
        read_check(A_MONTH, 8'h01, "roll_month");
        read_check(A_YEAR, 8'h00, "roll_year");
        read_check(A_CTRL, 8'h80, "roll_ctrl");

        // Register masks and CAL bits while frozen
        bus_write(A_HOUR, 8'hFF, 1'b1, 1'b0);
        read_check(A_HOUR, 8'h3F, "mask_hour");
        bus_write(A_CTRL, 8'h9F, 1'b1, 1'b0);
        read_check(A_CTRL, 8'h9F, "cal_ctrl");

        // Leap and non-leap February
        set_time(23, 59, 59, 3, 28, 2, 24);
        run_and_freeze(1);
        read_check(A_DATE, 8'h29, "leap_date");
        read_check(A_MONTH, 8'h02, "leap_month");
        read_check(A_DAY, 8'h04, "leap_day");
        set_time(23, 59, 59, 3, 28, 2, 23);
        run_and_freeze(1);
        read_check(A_DATE, 8'h01, "nonleap_date");
        read_check(A_MONTH, 8'h03, "nonleap_month");

        // Read snapshot while counters run
        set_time(0, 0, 10, 1, 1, 1, 0);
        bus_write(A_CTRL, 8'h40, 1'b1, 1'b0);
        repeat (10) begin @(posedge clk30); #1; end
        read_check(A_SEC, 8'h10, "snap_sec");
        bus_write(A_CTRL, 8'h00, 1'b1, 1'b0);
        read_check(A_SEC, 8'h13, "live_sec");

        // ST halts; counter writes ignored while W=0
        set_time(0, 0, 0, 1, 1, 1, 0);
        bus_write(A_SEC, 8'h80, 1'b1, 1'b0);
        bus_write(A_MIN, 8'h45, 1'b1, 1'b0);
        repeat (40) begin @(posedge clk30); #1; end
        read_check(A_SEC, 8'h80, "st_hold");
        read_check(A_MIN, 8'h00, "min_locked");
        bus_write(A_SEC, 8'h00, 1'b1, 1'b0);
        run_and_freeze(2);
        read_check(A_SEC, 8'h02, "st_resume");

        for (int it = 0; it < 6; it++) begin
            int n;
            m_year  = $urandom_range(0, 99);
            m_month = $urandom_range(1, 12);
            m_date  = ($urandom_range(0, 1) == 0) ? month_len(m_month, m_year)
                                                   : $urandom_range(1, month_len(m_month, m_year));
            m_hour  = ($urandom_range(0, 1) == 0) ? 23 : $urandom_range(0, 23);
            m_min   = ($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59);
            m_sec   = $urandom_range(55, 59);
            m_day   = $urandom_range(1, 7);
            n       = $urandom_range(1, 5);
            set_time(m_hour, m_min, m_sec, m_day, m_date, m_month, m_year);
            run_and_freeze(n);
            for (int k = 0; k < n; k++) model_tick();
            read_check(A_SEC, to_bcd(m_sec), "rnd_sec");
            read_check(A_MIN, to_bcd(m_min), "rnd_min");
            read_check(A_HOUR, to_bcd(m_hour), "rnd_hour");
            read_check(A_DAY, to_bcd(m_day), "rnd_day");
            read_check(A_DATE, to_bcd(m_date), "rnd_date");
            read_check(A_MONTH, to_bcd(m_month), "rnd_month");
            read_check(A_YEAR, to_bcd(m_year), "rnd_year");
        end
`else
        bus_write(A_SEC, 8'h77, 1'b1, 1'b0);
        bus_write(A_CTRL, 8'hC0, 1'b1, 1'b0);
        repeat (20) begin @(posedge clk30); #1; end
        read_check(A_SEC, 8'h77, "plain_sec");
        read_check(A_CTRL, 8'hC0, "plain_ctrl");
`endif

        // Held read strobe: ack must toggle
        begin
            logic exp_ack [5];
            exp_ack[0] = 1'b0; exp_ack[1] = 1'b1; exp_ack[2] = 1'b0;
            exp_ack[3] = 1'b1; exp_ack[4] = 1'b0;
            cs = 1'b1; write_strobe = 1'b0; addr = 13'h1000; uds = 1'b1;
            #1;
            for (int i = 0; i < 5; i++) begin
                if (i > 0) begin @(posedge clk30); #1; end
                check($sformatf("hold_ack%0d", i), bus_ack, exp_ack[i]);
            end
            cs = 1'b0; uds = 1'b0;
            @(posedge clk30); #1;
        end

        // Reset during ACK
        cs = 1'b1; write_strobe = 1'b0; addr = 13'h1000; uds = 1'b1;
        @(posedge clk30); #1;
        check("pre_rst_ack", bus_ack, 1'b1);
        check("pre_rst_dout", dout, 16'hA5A5);
        reset = 1'b1; cs = 1'b0; uds = 1'b0;
        @(posedge clk30); #1;
        check("mid_rst_ack", bus_ack, 1'b0);
        check("mid_rst_dout", dout, 16'h0000);
        reset = 1'b0;
        @(posedge clk30); #1;
        read_check(13'h1000, 8'hA5, "ram_kept");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
